vector_serializer: RTL and testbench

Transmit-side counterpart of the bit-to-vector buffer. Accepts 8-bit vectors over a valid/ready push port and buffers up to `NB_VECTORS` of them in a ring. On each bit request it serves them back out one bit per cycle, MSB first. Output order matches the receiver's shift-left fill, so serializer output fed into the receiver reproduces the original vectors.

---
 rtl/vec_pkg.sv | 10 +
 rtl/vector_ring.sv | 70 +++++++
 rtl/vector_serializer.sv | 102 ++++++++++
 tb/tb_vector_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector definitions for the serializer and the receive buffer.
// Both ends agree on the vector width and on MSB-first bit order.
package vec_pkg;

    localparam int VEC_WIDTH = 8;
    localparam int BITCNT_W  = $clog2(VEC_WIDTH);

    typedef logic [VEC_WIDTH-1:0] vec_t;

endpackage

// File: rtl/vector_ring.sv
// Vector ring buffer: storage, write/read pointers and occupancy level.
// Push is taken only when not full. Pop is taken only when not empty.
// Flush clears both pointers and the level, and it overrides push and pop.
// Slot contents are never reset; only the pointers decide what is valid.
module vector_ring
    import vec_pkg::*;
#(
    parameter  int NB_VECTORS = 16,
    localparam int PTR_W      = $clog2(NB_VECTORS),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  vec_t             push_data,
    input  logic             pop,
    input  logic             flush,
    output vec_t             head,
    output logic [LVL_W-1:0] level,
    output logic             full
);

    vec_t             mem [NB_VECTORS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(NB_VECTORS));
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & (level_q != '0) & ~flush;
    assign head    = mem[rd_ptr_q];
    assign level   = level_q;

    // Next pointer and level values; pointers wrap naturally at the ring depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write. The array has no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vector_serializer.sv
// Vector serializer: buffers pushed vectors and sends them out MSB first,
// one bit per request cycle.
//
// Push handshake: a vector is taken on a rising edge where vector_valid and
// vector_ready are both high. vector_ready depends only on the registered
// level, so a pop in the same cycle does not free a slot for that push.
// vector_valid may be raised or dropped at any time, and vector may change
// freely while vector_valid is low.
//
// bitcnt == 0 means that no vector is being sent. The vector being sent is
// held in the shift register and is not counted in level.
module vector_serializer
    import vec_pkg::*;
#(
    parameter  int NB_VECTORS = 16,
    localparam int LVL_W      = $clog2(NB_VECTORS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  vec_t             vector,
    input  logic             vector_valid,
    output logic             vector_ready,
    input  logic             flush,
    input  logic             bit_req,
    output logic             bit_out,      // serial data bit
    output logic             bit_valid,
    output logic [LVL_W-1:0] level
);

    logic                head;
    vec_t                head_vec;
    logic                ring_full;
    logic                pop;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    vec_t                shreg_q, shreg_d;
    logic                bit_q, bit_d;
    logic                bit_valid_q, bit_valid_d;

    vector_ring #(
        .NB_VECTORS (NB_VECTORS)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vector_valid),
        .push_data (vector),
        .pop       (pop),
        .flush     (flush),
        .head      (head_vec),
        .level     (level),
        .full      (ring_full)
    );

    assign vector_ready = ~ring_full;
    assign head         = head_vec[VEC_WIDTH-1];
    assign bit_out      = bit_q;
    assign bit_valid    = bit_valid_q;

    // Choose the next bit. The choice is: continue the vector in flight, start
    // the next vector from the ring head, or send nothing.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        bit_d       = 1'b0;
        bit_valid_d = 1'b0;
        pop         = 1'b0;
        if (flush) begin
            bitcnt_d = '0;
        end else if (bit_req) begin
            if (bitcnt_q != '0) begin
                bit_d       = shreg_q[VEC_WIDTH-1];
                bit_valid_d = 1'b1;
                shreg_d     = shreg_q << 1;
                bitcnt_d    = bitcnt_q + 1'b1;
            end else if (level != '0) begin
                bit_d       = head;
                bit_valid_d = 1'b1;
                shreg_d     = head_vec << 1;
                bitcnt_d    = BITCNT_W'(1);
                pop         = 1'b1;
            end
        end
    end

    // Bit counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q    <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            bitcnt_q    <= bitcnt_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    // Shift register. It has no reset; bitcnt decides whether its contents are used.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer: a table of single-cycle vectors,
// followed by hand-written multi-cycle sequences.
module tb_vector_serializer;

    localparam int NB    = 16;
    localparam int LVL_W = $clog2(NB) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       vector;
    logic             vector_valid;
    logic             vector_ready;
    logic             flush;
    logic             bit_req;
    logic             bit_out;
    logic             bit_valid;
    logic [LVL_W-1:0] level;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic             push;
        logic [7:0]       vec;
        logic             req;
        logic             flsh;
        logic             e_bit;
        logic             e_valid;
        logic [LVL_W-1:0] e_level;
        logic             e_ready;
    } row_t;

    row_t tbl[$];

    always #5 clk = ~clk;

    vector_serializer #(.NB_VECTORS(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .flush        (flush),
        .bit_req      (bit_req),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .level        (level)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Wait for a rising edge, then settle 1 time unit past it so that
    // outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [7:0] v, input logic r, input logic f);
        vector_valid = p;
        vector       = v;
        bit_req      = r;
        flush        = f;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic p, input logic [7:0] v, input logic r, input logic f,
                       input logic eb, input logic ev, input int el, input logic er);
        row_t t;
        t.push = p; t.vec = v; t.req = r; t.flsh = f;
        t.e_bit = eb; t.e_valid = ev; t.e_level = LVL_W'(el); t.e_ready = er;
        tbl.push_back(t);
    endtask

    // Hold bit_req high for 8 cycles and check that one whole vector comes out.
    task automatic drain_check(input string nm, input logic [7:0] expv);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
            chk($sformatf("%s_valid%0d", nm, i), 32'(bit_valid), 32'd1);
            acc = {acc[6:0], bit_out};
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk($sformatf("%s_vec", nm), 32'(acc), 32'(expv));
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] acc;
        int         nb;
        int         sent;
        int         rcvd;
        int         cyc;

        // ---------------- table-driven section ----------------
        // Single vector, then underflow.
        v = 8'hA5;
        add(1, v, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1, 0, v[7-i], 1, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1);
        // Request on alternate cycles: no bit may be lost.
        v = 8'hF0;
        add(1, v, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            add(0, 8'h00, 1, 0, v[7-i], 1, 0, 1);
            add(0, 8'h00, 0, 0, 0, 0, 0, 1);
        end
        add(0, 8'h00, 1, 0, 0, 0, 0, 1);
        // Two vectors sent back to back with no gap between them.
        add(1, 8'h3C, 0, 0, 0, 0, 1, 1);
        add(1, 8'h81, 0, 0, 0, 0, 2, 1);
        for (int i = 0; i < 16; i++) begin
            v = (i < 8) ? 8'h3C : 8'h81;
            add(0, 8'h00, 1, 0, v[7-(i%8)], 1, (i < 8) ? 1 : 0, 1);
        end
        add(0, 8'h00, 1, 0, 0, 0, 0, 1);

        do_reset();
        #1;
        chk("reset_bit", 32'(bit_out), 32'd0);
        chk("reset_valid", 32'(bit_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_ready", 32'(vector_ready), 32'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].push, tbl[i].vec, tbl[i].req, tbl[i].flsh);
            tick();
            chk($sformatf("row%0d_bit", i), 32'(bit_out), 32'(tbl[i].e_bit));
            chk($sformatf("row%0d_valid", i), 32'(bit_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d_level", i), 32'(level), 32'(tbl[i].e_level));
            chk($sformatf("row%0d_ready", i), 32'(vector_ready), 32'(tbl[i].e_ready));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // ---------------- fill to full, then pop and push together ----------------
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
            if (i >= 15) begin
                chk($sformatf("fill%0d_level", i), 32'(level), 32'd16);
                chk($sformatf("fill%0d_ready", i), 32'(vector_ready), 32'd0);
            end
        end
        // First-bit pop and a push in the same cycle on a full ring.
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        tick();
        chk("fullpop_level", 32'(level), 32'd15);
        chk("fullpop_valid", 32'(bit_valid), 32'd1);
        chk("fullpop_bit", 32'(bit_out), 32'd0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        acc = {7'b0, bit_out};
        nb  = 1;
        for (int n = 1; n < 128; n++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
            chk("drain_valid", 32'(bit_valid), 32'd1);
            acc = {acc[6:0], bit_out};
            nb++;
            if (nb == 8) begin
                nb = 0;
                if (exp_q.size() == 0) chk("drain_extra", 32'(acc), 32'hFFFF);
                else chk("drain_vec", 32'(acc), 32'(exp_q.pop_front()));
            end
        end
        tick();
        chk("drain_underflow", 32'(bit_valid), 32'd0);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // ---------------- wrap-around: 40 vectors, interleaved ----------------
        do_reset();
        sent = 0; rcvd = 0; cyc = 0; nb = 0; acc = '0;
        while (rcvd < 40 && cyc < 4000) begin
            drive((sent < 40) && ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0, 1'b0);
            if (vector_valid && vector_ready) begin
                exp_q.push_back(vector);
                sent++;
            end
            tick();
            cyc++;
            if (bit_valid) begin
                acc = {acc[6:0], bit_out};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    rcvd++;
                    if (exp_q.size() == 0) chk("wrap_extra", 32'(acc), 32'hFFFF);
                    else chk("wrap_vec", 32'(acc), 32'(exp_q.pop_front()));
                end
            end
        end
        chk("wrap_count", 32'(rcvd), 32'd40);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        exp_q.delete();

        // ---------------- flush mid-vector ----------------
        do_reset();
        drive(1'b1, 8'hC3, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
        chk("flush_pre_level", 32'(level), 32'd3);
        v = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
            chk($sformatf("flush_bit%0d", i), 32'(bit_out), 32'(v[7-i]));
        end
        chk("flush_mid_level", 32'(level), 32'd2);
        drive(1'b1, 8'h99, 1'b1, 1'b1);
        tick();
        chk("flush_valid", 32'(bit_valid), 32'd0);
        chk("flush_bit", 32'(bit_out), 32'd0);
        chk("flush_level", 32'(level), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("flush_underflow", 32'(bit_valid), 32'd0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        drain_check("flush_after", 8'h77);

        // ---------------- asynchronous reset mid-vector ----------------
        drive(1'b1, 8'hA5, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h3C, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        chk("arst_pre_valid", 32'(bit_valid), 32'd1);
        chk("arst_pre_level", 32'(level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bit_valid), 32'd0);
        chk("arst_bit", 32'(bit_out), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ready", 32'(vector_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        chk("arst_underflow", 32'(bit_valid), 32'd0);
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        tick();
        drain_check("arst_after", 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
